psg_stereo_mixer: RTL and testbench
===================================

Name: psg_stereo_mixer

Overview:
Downstream neighbour of the PSG core. Takes the 8-bit CHANNEL_A/B/C outputs of two PSG instances (TurboSound pair) and snapshots them at a fixed sample rate. Accumulates them serially into left/right stereo sums according to a selectable panning mode. Drives a first-order delta-sigma 1-bit DAC per side for the board audio pins, and exposes the parallel samples for digital sinks.

Parameters:
DIV, 16, sample period in CLK cycles; legal range 8..65535.

Ports:
CLK  in  1  system clock
RESET  in  1  reset; synchronous, active-high
A0  in  8  chip 0 channel A volume (unsigned)
B0  in  8  chip 0 channel B
C0  in  8  chip 0 channel C
A1  in  8  chip 1 channel A
B1  in  8  chip 1 channel B
C1  in  8  chip 1 channel C
STEREO  in  2  panning mode: 00 ABC, 01 ACB, 1x mono
CHIP_EN  in  2  per-chip enable; bit n=0 forces chip n contribution to 0
OUT_L  out  11  left sample (unsigned)
OUT_R  out  11  right sample (unsigned)
VALID  out  1  one-cycle pulse when OUT_L/OUT_R update
DAC_L  out  1  left delta-sigma bitstream
DAC_R  out  1  right delta-sigma bitstream

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - Outputs: OUT_L=0, OUT_R=0, VALID=0, DAC_L=0, DAC_R=0.
  - Internal: tick counter=0, FSM=IDLE, accumulators=0, snapshot regs=0, both delta-sigma integrators=0.
- Tick counter:
  - Counts 0..DIV-1, wraps to 0.
  - tick is asserted in the cycle the counter equals DIV-1.
  - First tick occurs DIV cycles after reset release.
- FSM states: IDLE, ACC0..ACC5, DONE.
  - IDLE: on tick, latch A0..C1, STEREO and CHIP_EN into snapshot regs, clear acc_l/acc_r, go ACC0.
  - ACCk (k=0..5): add the contribution of slot k to acc_l/acc_r; go ACC(k+1), or DONE from ACC5.
    - Slots: 0=A0, 1=B0, 2=C0, 3=A1, 4=B1, 5=C1.
    - A disabled chip's slots add 0.
  - DONE: OUT_L<=acc_l, OUT_R<=acc_r, VALID<=1 for this cycle only, go IDLE.
  - Latency: snapshot at tick cycle T; OUT/VALID registered at T+8 (visible the cycle after DONE).
  - Inputs changing after T do not affect that sample.
  - Because DIV>=8, a tick never arrives outside IDLE. If it does (illegal DIV), it is ignored.
- Contributions (per enabled chip, using snapshot values):
  - ABC: L += 2A+B; R += 2C+B.
  - ACB: L += 2A+C; R += 2B+C.
  - Mono (1x): L += A+B+C; R += A+B+C.
- Width rules:
  - Each addition is zero-extended to 11 bits.
  - Max per side is 1530 (2*255+255 per chip, two chips), so no overflow and no saturation logic.
  - Result is unsigned.
- Delta-sigma, per side, every CLK:
  - {DAC_x, integ_x[10:0]} <= integ_x + OUT_x (12-bit sum; carry is the output bit).
  - With OUT_x held at value V, exactly V ones are produced in any 2048 consecutive cycles after the integrator state aligns.
  - OUT_x=0 gives a constant 0.
- Simultaneous events:
  - RESET together with tick: reset wins, no snapshot.
  - An OUT update and the DAC integrator update in the same cycle: the integrator uses the old OUT value that cycle.

Test Plan:
- Reset: hold RESET 3 cycles with all inputs 8'hFF.
  - Required: all outputs 0; first VALID exactly DIV+8 cycles after RESET deasserts.
- ABC routing: A0=255, B0=100, C0=10, chip1 all 0, CHIP_EN=11, STEREO=00.
  - Required: OUT_L=610, OUT_R=120 with VALID.
- ACB and mono, same inputs:
  - STEREO=01 required: OUT_L=520, OUT_R=210.
  - STEREO=10 required: OUT_L=OUT_R=365.
- Full scale and chip mask: all six inputs 255, STEREO=00.
  - CHIP_EN=11 required: OUT_L=OUT_R=1530.
  - CHIP_EN=01 required: 765.
  - CHIP_EN=00 required: 0.
- Snapshot isolation: change A0 from 255 to 0 in cycle T+2 of a sample.
  - Required: that sample still shows the 255 contribution; the next sample reflects 0.
- DAC density: hold OUT_L=1024, OUT_R=1530, count ones over 2048 cycles after 2048 settle cycles.
  - Required: DAC_L count=1024 with strict alternation 0101…; DAC_R count=1530.
  - OUT=0 required: DAC stays 0.

Source files
------------

// File: rtl/psg_stereo_mixer.sv
// Stereo mixer for a TurboSound PSG pair: snapshots six channel volumes per sample period,
// accumulates them serially into left/right sums and drives a 1-bit delta-sigma DAC per side.
module psg_stereo_mixer #(
    parameter int unsigned DIV = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  A0,
    input  logic [7:0]  B0,
    input  logic [7:0]  C0,
    input  logic [7:0]  A1,
    input  logic [7:0]  B1,
    input  logic [7:0]  C1,
    input  logic [1:0]  STEREO,
    input  logic [1:0]  CHIP_EN,
    output logic [10:0] OUT_L,
    output logic [10:0] OUT_R,
    output logic        VALID,
    output logic        DAC_L,
    output logic        DAC_R
);

    typedef enum logic [2:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StAcc2,
        StAcc3,
        StAcc4,
        StAcc5,
        StDone
    } state_e;

    localparam logic [15:0] TickLast = 16'(DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] tick_cnt_q;
    logic        tick;

    logic [7:0]  snap_q [6];
    logic [1:0]  stereo_q;
    logic [1:0]  chip_en_q;
    logic        load_snap;

    logic [10:0] acc_l_q, acc_l_d;
    logic [10:0] acc_r_q, acc_r_d;
    logic [10:0] out_l_q, out_l_d;
    logic [10:0] out_r_q, out_r_d;
    logic        valid_q, valid_d;

    logic [10:0] integ_l_q, integ_r_q;
    logic        dac_l_q, dac_r_q;

    logic [2:0]  slot;
    logic [7:0]  vol;
    logic        chip_on;
    logic [1:0]  chan;
    logic [10:0] vol_x1, vol_x2;
    logic [10:0] add_l, add_r;

    assign tick = (tick_cnt_q == TickLast);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    // Slot decode: StAcc0..StAcc5 map onto slots 0..5 (A0 B0 C0 A1 B1 C1)
    always_comb begin
        slot = 3'(state_q) - 3'd1;
        case (slot)
            3'd0:    vol = snap_q[0];
            3'd1:    vol = snap_q[1];
            3'd2:    vol = snap_q[2];
            3'd3:    vol = snap_q[3];
            3'd4:    vol = snap_q[4];
            3'd5:    vol = snap_q[5];
            default: vol = 8'd0;
        endcase
        chip_on = (slot < 3'd3) ? chip_en_q[0] : chip_en_q[1];
        case (slot)
            3'd0, 3'd3: chan = 2'd0;
            3'd1, 3'd4: chan = 2'd1;
            default:    chan = 2'd2;
        endcase
        vol_x1 = {3'b000, vol};
        vol_x2 = {2'b00, vol, 1'b0};
    end

    // Per-slot contribution to each side for the latched panning mode
    always_comb begin
        add_l = '0;
        add_r = '0;
        if (chip_on) begin
            case (stereo_q)
                2'b00: begin
                    case (chan)
                        2'd0:    add_l = vol_x2;
                        2'd1:    begin add_l = vol_x1; add_r = vol_x1; end
                        default: add_r = vol_x2;
                    endcase
                end
                2'b01: begin
                    case (chan)
                        2'd0:    add_l = vol_x2;
                        2'd1:    add_r = vol_x2;
                        default: begin add_l = vol_x1; add_r = vol_x1; end
                    endcase
                end
                default: begin
                    add_l = vol_x1;
                    add_r = vol_x1;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        valid_d   = 1'b0;
        load_snap = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    load_snap = 1'b1;
                    acc_l_d   = '0;
                    acc_r_d   = '0;
                    state_d   = StAcc0;
                end
            end
            StDone: begin
                out_l_d = acc_l_q;
                out_r_d = acc_r_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                acc_l_d = acc_l_q + add_l;
                acc_r_d = acc_r_q + add_r;
                state_d = (state_q == StAcc5) ? StDone : state_e'(3'(state_q) + 3'd1);
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            valid_q   <= 1'b0;
            stereo_q  <= '0;
            chip_en_q <= '0;
            for (int i = 0; i < 6; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
            valid_q <= valid_d;
            if (load_snap) begin
                snap_q[0] <= A0;
                snap_q[1] <= B0;
                snap_q[2] <= C0;
                snap_q[3] <= A1;
                snap_q[4] <= B1;
                snap_q[5] <= C1;
                stereo_q  <= STEREO;
                chip_en_q <= CHIP_EN;
            end
        end
    end

    // First-order delta-sigma: carry of integrator + sample is the output bit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            {dac_l_q, integ_l_q} <= '0;
            {dac_r_q, integ_r_q} <= '0;
        end else begin
            {dac_l_q, integ_l_q} <= {1'b0, integ_l_q} + {1'b0, out_l_q};
            {dac_r_q, integ_r_q} <= {1'b0, integ_r_q} + {1'b0, out_r_q};
        end
    end

    assign OUT_L = out_l_q;
    assign OUT_R = out_r_q;
    assign VALID = valid_q;
    assign DAC_L = dac_l_q;
    assign DAC_R = dac_r_q;

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Scoreboard bench for psg_stereo_mixer: a sample-level model queues expected sums at each
// snapshot instant and a monitor compares them whenever VALID is seen.
module tb_psg_stereo_mixer;

    localparam int unsigned DIV = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  A0, B0, C0, A1, B1, C1;
    logic [1:0]  STEREO, CHIP_EN;
    logic [10:0] OUT_L, OUT_R;
    logic        VALID, DAC_L, DAC_R;

    int n_checks = 0;
    int n_pass   = 0;
    int ecnt     = 0;
    int n_push   = 0;
    int exp_l_q[$];
    int exp_r_q[$];

    psg_stereo_mixer #(.DIV(DIV)) dut (
        .CLK(CLK), .RESET(RESET),
        .A0(A0), .B0(B0), .C0(C0), .A1(A1), .B1(B1), .C1(C1),
        .STEREO(STEREO), .CHIP_EN(CHIP_EN),
        .OUT_L(OUT_L), .OUT_R(OUT_R), .VALID(VALID), .DAC_L(DAC_L), .DAC_R(DAC_R)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // One chip's contribution to one side, straight from the panning rules
    function automatic int chip_side(input int a, input int b, input int c,
                                     input logic [1:0] st, input bit left);
        if (st == 2'b00) return left ? 2 * a + b : 2 * c + b;
        if (st == 2'b01) return left ? 2 * a + c : 2 * b + c;
        return a + b + c;
    endfunction

    function automatic int side_sum(input bit left);
        int s = 0;
        if (CHIP_EN[0]) s += chip_side(A0, B0, C0, STEREO, left);
        if (CHIP_EN[1]) s += chip_side(A1, B1, C1, STEREO, left);
        return s;
    endfunction

    // Edges after reset release are numbered 1,2,...; a sample is taken at every DIV-th edge
    always @(posedge CLK) begin
        if (RESET) begin
            ecnt <= 0;
        end else begin
            ecnt <= ecnt + 1;
            if ((ecnt + 1) % DIV == 0) begin
                exp_l_q.push_back(side_sum(1'b1));
                exp_r_q.push_back(side_sum(1'b0));
                n_push++;
            end
        end
    end

    always @(negedge CLK) begin
        int el, er;
        if (!RESET && VALID) begin
            if (exp_l_q.size() == 0) begin
                check("unexpected VALID", 1, 0);
            end else begin
                el = exp_l_q.pop_front();
                er = exp_r_q.pop_front();
                check("OUT_L", int'(OUT_L), el);
                check("OUT_R", int'(OUT_R), er);
            end
        end
    end

    task automatic set_in(input int a0, input int b0, input int c0, input int a1, input int b1,
                          input int c1, input logic [1:0] st, input logic [1:0] en);
        A0 = 8'(a0); B0 = 8'(b0); C0 = 8'(c0);
        A1 = 8'(a1); B1 = 8'(b1); C1 = 8'(c1);
        STEREO = st; CHIP_EN = en;
    endtask

    // Returns #1 after the edge at which a snapshot was just taken
    task automatic next_period();
        do begin
            @(posedge CLK);
            #1;
        end while (ecnt % DIV != 0);
    endtask

    task automatic count_dac(input int cycles, output int ones_l, output int ones_r,
                             output int alt_err);
        logic prev;
        ones_l = 0; ones_r = 0; alt_err = 0;
        @(negedge CLK);
        prev = ~DAC_L;
        for (int i = 0; i < cycles; i++) begin
            ones_l += int'(DAC_L);
            ones_r += int'(DAC_R);
            if (DAC_L == prev) alt_err++;
            prev = DAC_L;
            @(negedge CLK);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int n, ol, orr, alt;
        set_in(255, 255, 255, 255, 255, 255, 2'b11, 2'b11);
        repeat (3) @(posedge CLK);
        #1;
        check("reset OUT_L", int'(OUT_L), 0);
        check("reset OUT_R", int'(OUT_R), 0);
        check("reset VALID", int'(VALID), 0);
        check("reset DAC_L", int'(DAC_L), 0);
        check("reset DAC_R", int'(DAC_R), 0);
        RESET = 1'b0;

        // VALID is visible in cycle DIV+8 after release, i.e. after edge DIV+7
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!VALID && n < 4 * DIV);
        check("first VALID latency", n, DIV + 7);

        next_period(); set_in(255, 100, 10, 0, 0, 0, 2'b00, 2'b11);
        next_period(); set_in(255, 100, 10, 0, 0, 0, 2'b01, 2'b11);
        next_period(); set_in(255, 100, 10, 0, 0, 0, 2'b10, 2'b11);
        next_period(); set_in(255, 255, 255, 255, 255, 255, 2'b00, 2'b11);
        next_period(); set_in(255, 255, 255, 255, 255, 255, 2'b00, 2'b01);
        next_period(); set_in(255, 255, 255, 255, 255, 255, 2'b00, 2'b00);
        next_period(); set_in(255, 100, 10, 0, 0, 0, 2'b00, 2'b11);

        // Snapshot isolation: A0 drops two cycles after the snapshot
        next_period();
        repeat (2) @(posedge CLK);
        #1;
        A0 = 8'd0;

        for (int i = 0; i < 24; i++) begin
            next_period();
            set_in($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, DIV - 3)) @(posedge CLK);
            #1;
            if ($urandom_range(0, 1) == 1) begin
                A0 = 8'($urandom_range(0, 255));
                C1 = 8'($urandom_range(0, 255));
                STEREO = 2'($urandom_range(0, 3));
            end
        end

        // L = 2*255+255 + 2*2+255 = 1024, R = 2 * (2*255+255) = 1530
        next_period(); set_in(255, 255, 255, 2, 255, 255, 2'b00, 2'b11);
        repeat (2048) @(posedge CLK);
        count_dac(2048, ol, orr, alt);
        check("DAC_L ones at 1024", ol, 1024);
        check("DAC_L alternation errors", alt, 0);
        check("DAC_R ones at 1530", orr, 1530);

        next_period(); set_in(0, 0, 0, 0, 0, 0, 2'b00, 2'b11);
        next_period();
        repeat (DIV) @(posedge CLK);
        count_dac(256, ol, orr, alt);
        check("DAC_L ones at 0", ol, 0);
        check("DAC_R ones at 0", orr, 0);

        next_period();
        repeat (DIV / 2 + 2) @(posedge CLK);
        #1;
        check("pending samples", exp_l_q.size(), 0);
        check("samples issued", n_push > 30 ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
